// File: rtl/sdram_arb_pkg.sv
// Shared encodings, default widths and helpers for the SDRAM host-port arbiter.
package sdram_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int unsigned DEF_NUM_PORTS     = 4;
    localparam int unsigned DEF_HADDR_WIDTH   = 24;
    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned DEF_START_TIMEOUT = 63;

    // Width needed to index n items; never less than 1 bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/sdram_host_arbiter_rr_arbiter.sv
// Round-robin grant selection with a registered rotating priority pointer.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter int unsigned IDX_W     = clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 advance,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_any
);

    logic [IDX_W-1:0] ptr;

    // Scan from the pointer upward, wrapping, and take the first request.
    always_comb begin
        int unsigned p;
        logic [IDX_W-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        p         = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            p = 32'(ptr) + k;
            if (p >= NUM_PORTS) p = p - NUM_PORTS;
            idx = IDX_W'(p);
            if (!grant_any && req[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_any) begin
            ptr <= (32'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Shares the SDRAM controller host port among NUM_PORTS requesters, one word per grant.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS     = DEF_NUM_PORTS,
    parameter int unsigned HADDR_WIDTH   = DEF_HADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned START_TIMEOUT = DEF_START_TIMEOUT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [HADDR_WIDTH-1:0]          ctrl_haddr,
    output logic [DATA_WIDTH-1:0]           ctrl_data_input,
    input  logic [DATA_WIDTH-1:0]           ctrl_data_output,
    input  logic                            ctrl_busy,
    output logic                            ctrl_rd_enable,
    output logic                            ctrl_wr_enable
);

    localparam int unsigned IDX_W = clog2(NUM_PORTS);
    localparam int unsigned CNT_W = clog2(START_TIMEOUT + 1);

    logic [1:0]             state;
    logic                   we_q;
    logic [HADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   err_q;

    logic [NUM_PORTS-1:0]   grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic                   accept;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign accept    = (state == IDLE) && grant_any && !rst;
    assign req_ready = accept ? grant : '0;
    assign cnt_inc   = cnt + 1'b1;

    // Enables are gated by rst so they drop in the very cycle reset is sampled.
    assign ctrl_rd_enable  = (state == ISSUE) && !we_q && !rst;
    assign ctrl_wr_enable  = (state == ISSUE) &&  we_q && !rst;
    assign ctrl_haddr      = addr_q;
    assign ctrl_data_input = wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            idx_q     <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        we_q    <= req_we[grant_idx];
                        addr_q  <= req_addr[32'(grant_idx)*HADDR_WIDTH +: HADDR_WIDTH];
                        wdata_q <= req_wdata[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                        idx_q   <= grant_idx;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Busy already high on entry is taken as the start of the access.
                    cnt <= cnt_inc;
                    if (ctrl_busy) begin
                        state <= ACTIVE;
                    end else if (32'(cnt_inc) >= START_TIMEOUT) begin
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                ACTIVE: begin
                    if (!ctrl_busy) begin
                        if (!we_q) rsp_rdata <= ctrl_data_output;
                        state <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid[idx_q] <= 1'b1;
                    rsp_err          <= err_q;
                    cnt              <= '0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Randomized scoreboard bench for sdram_host_arbiter with a behavioural SDRAM controller model.
module tb_sdram_host_arbiter;

    localparam int NP = 4;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 63;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     req_valid = '0;
    logic [NP-1:0]     req_we = '0;
    logic [NP*AW-1:0]  req_addr = '0;
    logic [NP*DW-1:0]  req_wdata = '0;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic              rsp_err;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     ctrl_haddr;
    logic [DW-1:0]     ctrl_data_input;
    logic [DW-1:0]     ctrl_data_output = '0;
    logic              ctrl_busy = 1'b0;
    logic              ctrl_rd_enable;
    logic              ctrl_wr_enable;

    sdram_host_arbiter #(
        .NUM_PORTS     (NP),
        .HADDR_WIDTH   (AW),
        .DATA_WIDTH    (DW),
        .START_TIMEOUT (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_we           (req_we),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_err          (rsp_err),
        .rsp_rdata        (rsp_rdata),
        .ctrl_haddr       (ctrl_haddr),
        .ctrl_data_input  (ctrl_data_input),
        .ctrl_data_output (ctrl_data_output),
        .ctrl_busy        (ctrl_busy),
        .ctrl_rd_enable   (ctrl_rd_enable),
        .ctrl_wr_enable   (ctrl_wr_enable)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SDRAM controller model ----------------
    int  busy_len = 6;
    int  refresh_delay = 0;
    bit  never_busy = 1'b0;
    int  accesses = 0;
    int  bcnt = 0;
    int  ign = 0;
    logic [DW-1:0] cmem [logic [AW-1:0]];

    always @(posedge clk) begin
        if (rst) begin
            ctrl_busy        <= 1'b0;
            ctrl_data_output <= '0;
            bcnt = 0;
            ign  = 0;
        end else if (bcnt != 0) begin
            bcnt--;
            if (bcnt == 0) ctrl_busy <= 1'b0;
        end else if ((ctrl_rd_enable || ctrl_wr_enable) && !never_busy) begin
            if (ign < refresh_delay) begin
                ign++;
            end else begin
                ign = 0;
                accesses++;
                if (ctrl_wr_enable) cmem[ctrl_haddr] = ctrl_data_input;
                else ctrl_data_output <= cmem.exists(ctrl_haddr) ? cmem[ctrl_haddr] : '0;
                ctrl_busy <= 1'b1;
                bcnt = busy_len;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int            port;
        bit            err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    int            grants[$];
    int            ref_ptr = 0;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_last_rd = '0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_wdata = '0;
    bit            cur_we = 1'b0;
    int            en_run = 0;
    int            last_en_len = 0;

    logic [AW-1:0] b_addr [NP];
    logic [DW-1:0] b_wdata [NP];
    bit            b_we [NP];
    logic [AW-1:0] pool [8];

    function automatic int ref_pick(input logic [NP-1:0] m);
        for (int k = 0; k < NP; k++) begin
            if (m[(ref_ptr + k) % NP]) return (ref_ptr + k) % NP;
        end
        return -1;
    endfunction

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        logic [NP-1:0] oh;
        if (!rst && rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
            end else begin
                e = exp_q.pop_front();
                oh = '0;
                oh[e.port] = 1'b1;
                check("rsp_valid", 64'(rsp_valid), 64'(oh));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
    end

    // Controller-side command monitor: address/direction/data must stay as latched.
    always @(negedge clk) begin
        if (!rst && (ctrl_rd_enable || ctrl_wr_enable || ctrl_busy)) begin
            check("cmd_addr", 64'(ctrl_haddr), 64'(cur_addr));
            if (ctrl_rd_enable || ctrl_wr_enable)
                check("cmd_dir", 64'({ctrl_wr_enable, ctrl_rd_enable}), cur_we ? 64'd2 : 64'd1);
            if (cur_we) check("cmd_wdata", 64'(ctrl_data_input), 64'(cur_wdata));
        end
        if (ctrl_rd_enable || ctrl_wr_enable) begin
            en_run++;
        end else if (en_run != 0) begin
            last_en_len = en_run;
            en_run = 0;
        end
    end

    task automatic run_batch(input logic [NP-1:0] mask, input int reps, input bit err_exp, input bit scramble);
        int   left [NP];
        int   guard;
        int   g;
        int   total;
        exp_t e;
        logic [NP-1:0] oh;
        total = 0;
        for (int i = 0; i < NP; i++) begin
            left[i] = mask[i] ? reps : 0;
            total += left[i];
        end
        @(posedge clk); #1;
        for (int i = 0; i < NP; i++) begin
            req_valid[i]            = left[i] > 0;
            req_we[i]               = b_we[i];
            req_addr[i*AW +: AW]    = b_addr[i];
            req_wdata[i*DW +: DW]   = b_wdata[i];
        end
        guard = 0;
        while (total > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (req_ready != '0) begin
                g = ref_pick(req_valid);
                oh = '0;
                oh[g] = 1'b1;
                check("req_ready", 64'(req_ready), 64'(oh));
                ref_ptr = (g + 1) % NP;
                grants.push_back(g);
                e.port = g;
                e.err  = err_exp;
                if (!err_exp) begin
                    if (b_we[g]) ref_mem[b_addr[g]] = b_wdata[g];
                    else ref_last_rd = ref_mem.exists(b_addr[g]) ? ref_mem[b_addr[g]] : '0;
                end
                e.rdata = ref_last_rd;
                exp_q.push_back(e);
                cur_addr  = b_addr[g];
                cur_we    = b_we[g];
                cur_wdata = b_wdata[g];
                left[g]--;
                total--;
                @(posedge clk); #1;
                req_valid[g] = left[g] > 0;
                if (scramble) begin
                    req_addr[g*AW +: AW]  = AW'($urandom);
                    req_wdata[g*DW +: DW] = DW'($urandom);
                    req_we[g]             = ~req_we[g];
                end
            end
        end
        if (total > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout: got %0d grants outstanding expected 0", total);
            req_valid = '0;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rsp_timeout: got %0d responses missing expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_port(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        b_we[p] = we;
        b_addr[p] = a;
        b_wdata[p] = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        int acc0;
        int guard;
        for (int i = 0; i < 8; i++) pool[i] = AW'($urandom);
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, '0, '0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, ctrl_rd_enable, ctrl_wr_enable}), 64'd0);
        check("reset_haddr", 64'(ctrl_haddr), 64'd0);
        check("reset_wdata", 64'(ctrl_data_input), 64'd0);
        rst = 1'b0;

        // All ports reading continuously: strict round robin from pointer 0
        busy_len = 2;
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, pool[i], '0);
        run_batch(4'b1111, 2, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) check($sformatf("rr_order_%0d", k), 64'(grants[k]), 64'(k % NP));

        // Port 2 write then read with a 6-cycle busy controller
        busy_len = 6;
        set_port(2, 1'b1, 24'h012345, 16'hBEEF);
        run_batch(4'b0100, 1, 1'b0, 1'b0);
        set_port(2, 1'b0, 24'h012345, 16'h0000);
        run_batch(4'b0100, 1, 1'b0, 1'b0);
        check("read_beef", 64'(rsp_rdata), 64'h0000_BEEF);

        // Refresh holds off busy for 11 enable cycles
        busy_len = 3;
        refresh_delay = 10;
        acc0 = accesses;
        set_port(1, 1'b0, 24'h012345, 16'h0000);
        run_batch(4'b0010, 1, 1'b0, 1'b0);
        check("refresh_one_access", 64'(accesses - acc0), 64'd1);
        check("refresh_en_held", 64'(last_en_len >= 11), 64'd1);
        refresh_delay = 0;

        // Controller never starts: timeout after 63 issue cycles, write not performed
        never_busy = 1'b1;
        set_port(3, 1'b1, 24'h012345, 16'h1234);
        run_batch(4'b1000, 1, 1'b1, 1'b0);
        check("timeout_en_len", 64'(last_en_len), 64'(TO));
        never_busy = 1'b0;
        set_port(3, 1'b0, 24'h012345, 16'h0000);
        run_batch(4'b1000, 1, 1'b0, 1'b0);
        check("after_timeout_read", 64'(rsp_rdata), 64'h0000_BEEF);

        // Port 1 drops its request and changes address right after acceptance
        busy_len = 5;
        set_port(1, 1'b1, 24'hABCDE1, 16'h5A5A);
        run_batch(4'b0010, 1, 1'b0, 1'b1);
        set_port(1, 1'b0, 24'hABCDE1, 16'h0000);
        run_batch(4'b0010, 1, 1'b0, 1'b1);
        check("scramble_read", 64'(rsp_rdata), 64'h0000_5A5A);

        // Reset during ACTIVE of a port 0 read
        busy_len = 8;
        set_port(0, 1'b0, 24'hABCDE1, 16'h0000);
        @(posedge clk); #1;
        req_we = '0;
        req_addr[0 +: AW] = 24'hABCDE1;
        req_valid = 4'b0001;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (req_ready == '0 && guard < 50);
        check("rst_test_grant", 64'(req_ready), 64'd1);
        cur_addr = 24'hABCDE1;
        cur_we = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(ctrl_busy && !ctrl_rd_enable) && guard < 50);
        check("rst_test_active", 64'(ctrl_busy && !ctrl_rd_enable), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_enables_drop", 64'({ctrl_rd_enable, ctrl_wr_enable}), 64'd0);
        @(posedge clk); #1;
        check("rst_outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_rdata, ctrl_rd_enable, ctrl_wr_enable}), 64'd0);
        check("rst_haddr", 64'(ctrl_haddr), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        ref_ptr = 0;
        ref_last_rd = '0;
        repeat (12) @(negedge clk);
        grants.delete();
        set_port(0, 1'b0, 24'h012345, '0);
        set_port(1, 1'b0, 24'hABCDE1, '0);
        busy_len = 2;
        run_batch(4'b0011, 1, 1'b0, 1'b0);
        check("post_rst_first_grant", 64'(grants[0]), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NP; i++)
                set_port(i, 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], DW'($urandom));
            busy_len = $urandom_range(1, 8);
            refresh_delay = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_batch(NP'($urandom_range(1, 15)), $urandom_range(1, 2), 1'b0, 1'b0);
        end
        refresh_delay = 0;

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
